fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the 16x8 asynchronous FIFO; lives entirely in the write_clk domain.
- Shares the single FIFO write port among NREQ requesters using round-robin arbitration with packet locking.
- Drives the FIFO's write enable and data, and back-pressures requesters from the FIFO's full flag.
- Guarantees a packet is never interleaved with another requester's data, and bounds grant hold time with MAX_BURST.

---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking write scheduler for the 16x8 async FIFO (write_clk domain).
// Optional per-requester beat / stall statistics: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned WID       = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 write_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WID-1:0]  req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [WID-1:0]       fifo_wr_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   stat_beats,
  output logic [15:0]          stat_stall
`endif
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STAT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             in_burst;
  logic             own_valid;
  logic             own_last;
  logic [WID-1:0]   own_data;
  logic             xfer;
  logic             release_c;
  logic             win_found;
  logic [IDW-1:0]   win_idx;

  assign in_burst  = (state_q == BURST);
  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[32'(grant_q) * WID +: WID];
  assign xfer      = in_burst & own_valid & ~fifo_full;
  // Grant ends on the packet's last beat or on the MAX_BURST-th beat, whichever comes first.
  assign release_c = own_last | (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Round-robin search starting one past the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!win_found && req_valid[IDW'((32'(rr_ptr_q) + k) % NREQ)]) begin
        win_found = 1'b1;
        win_idx   = IDW'((32'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (!in_burst) begin
      if (win_found) begin
        state_d    = BURST;
        grant_d    = win_idx;
        beat_cnt_d = '0;
      end
    end else if (xfer) begin
      if (release_c) begin
        state_d    = IDLE;
        rr_ptr_d   = grant_q;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IDW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = in_burst ? own_data : '0;
  assign grant_id     = grant_q;
  assign busy         = in_burst;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] beats_q [NREQ];
  logic [STAT_W-1:0] stall_q;

  // Saturating counters: never wrap past all-ones.
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        beats_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      if (xfer && (beats_q[grant_q] != '1)) begin
        beats_q[grant_q] <= beats_q[grant_q] + STAT_W'(1);
      end
      if (in_burst && own_valid && fifo_full && (stall_q != '1)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_beats[i*STAT_W +: STAT_W] = beats_q[i];
    end
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue-fed requesters against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int unsigned WID       = 8;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned IDW       = 2;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned VW        = 1 + IDW + NREQ + 1 + WID;

  logic                write_clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*WID-1:0] req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [WID-1:0]      fifo_wr_data;
  logic [IDW-1:0]      grant_id;
  logic                busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]  stat_beats;
  logic [15:0]         stat_stall;
`endif

  fifo_wr_arbiter #(
    .WID(WID), .NREQ(NREQ), .IDW(IDW), .MAX_BURST(MAX_BURST)
  ) dut (
    .write_clk    (write_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_beats   (stat_beats),
    .stat_stall   (stat_stall),
`endif
    .busy         (busy)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;

  // Requester packet sources: {last, data} per entry
  logic [WID:0] src [NREQ][256];
  int hd [NREQ];
  int tl [NREQ];
  int gap_pct;
  int full_mode;
  logic full_tog;

  // Reference model
  bit m_busy;
  int m_owner, m_rr, m_beats_in_grant, m_stall;
  int m_beats [NREQ];

  // Observations
  logic [VW-1:0] exp_vec, obs_vec;
  logic [NREQ-1:0] obs_ready;
  logic obs_wr;
  int cyc, n_wr, n_gr;
  int wr_cyc [64];
  logic [WID-1:0] wr_dat [64];
  int gr [64];
  bit prev_busy;

  function automatic int pick(int rr, logic [NREQ-1:0] v);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (v[IDW'((rr + k) % int'(NREQ))]) return (rr + k) % int'(NREQ);
    end
    return -1;
  endfunction

  task automatic push_pkt(int r, int len, logic [WID-1:0] base);
    for (int b = 0; b < len; b++) begin
      src[r][tl[r] % 256] = {(b == len - 1), base + WID'(b)};
      tl[r]++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = NREQ - 1; m_beats_in_grant = 0; m_stall = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      m_beats[i] = 0; hd[i] = 0; tl[i] = 0;
    end
    cyc = 0; n_wr = 0; n_gr = 0; prev_busy = 0;
    gap_pct = 0; full_mode = 0; full_tog = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    @(posedge write_clk); @(posedge write_clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive from sources, sample at negedge, advance the model at posedge.
  task automatic cycle();
    logic [IDW-1:0] og, eg, ogid;
    logic [NREQ-1:0] er;
    logic [WID-1:0] ed;
    logic xe;
    int p;
    req_valid = '0; req_last = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_data[i*WID +: WID] = WID'($urandom);
      if (hd[i] != tl[i]) begin
        req_data[i*WID +: WID] = src[i][hd[i] % 256][WID-1:0];
        req_last[i]  = src[i][hd[i] % 256][WID];
        req_valid[i] = (int'($urandom_range(99)) >= gap_pct);
      end
    end
    case (full_mode)
      0: fifo_full = 1'b0;
      1: fifo_full = 1'b1;
      2: begin full_tog = ~full_tog; fifo_full = full_tog; end
      default: fifo_full = ($urandom_range(99) < 30);
    endcase
    @(negedge write_clk);
    og = IDW'(m_owner);
    xe = m_busy && req_valid[og] && !fifo_full;
    eg = m_busy ? og : '0;
    er = '0;
    if (m_busy && !fifo_full) er[og] = 1'b1;
    ed = m_busy ? req_data[m_owner*WID +: WID] : '0;
    exp_vec = {m_busy, eg, er, xe, ed};
    ogid = busy ? grant_id : '0;
    obs_vec = {busy, ogid, req_ready, fifo_wr_en, fifo_wr_data};
    obs_ready = req_ready; obs_wr = fifo_wr_en;
    if (busy && !prev_busy && n_gr < 64) begin gr[n_gr] = int'(grant_id); n_gr++; end
    prev_busy = busy;
    if (fifo_wr_en === 1'b1) begin
      if (n_wr < 64) begin wr_cyc[n_wr] = cyc; wr_dat[n_wr] = fifo_wr_data; end
      n_wr++;
    end
    @(posedge write_clk);
    if (!m_busy) begin
      p = pick(m_rr, req_valid);
      if (p >= 0) begin m_busy = 1; m_owner = p; m_beats_in_grant = 0; end
    end else if (xe) begin
      m_beats_in_grant++;
      hd[m_owner]++;
      if (m_beats[m_owner] < 65535) m_beats[m_owner]++;
      if (req_last[og] || m_beats_in_grant == int'(MAX_BURST)) begin
        m_busy = 0; m_rr = m_owner;
      end
    end else if (req_valid[og] && fifo_full && m_stall < 65535) begin
      m_stall++;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_last = '0; req_data = 32'hDEADBEEF; fifo_full = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", fifo_wr_data); end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++; if (stat_beats !== '0 || stat_stall !== '0) begin
      errors++; $display("FAIL reset_stats: got %h/%h want 0", stat_beats, stat_stall); end
`endif
    do_reset();
  endtask

  task automatic test_single_packet();
    do_reset();
    push_pkt(2, 3, 8'hA0);
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL single_pkt cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_gr !== 1 || gr[0] !== 2) begin errors++; $display("FAIL single_grant: got n=%0d id=%0d want 1/2", n_gr, gr[0]); end
    checks++; if (n_wr !== 3) begin errors++; $display("FAIL single_nwr: got %0d want 3", n_wr); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_cyc[i] !== i + 1 || wr_dat[i] !== 8'hA0 + WID'(i)) begin errors++;
        $display("FAIL single_beat%0d: got cyc %0d data %h want cyc %0d data %h", i, wr_cyc[i], wr_dat[i], i + 1, 8'hA0 + WID'(i)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release: busy %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < int'(NREQ); r++)
      for (int k = 0; k < 4; k++) push_pkt(r, 1, WID'(r * 16 + k));
    for (int c = 0; c < 16; c++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL rr cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL rr_nwr: got %0d want 8", n_wr); end
    checks++; if (n_gr !== 8) begin errors++; $display("FAIL rr_ngrant: got %0d want 8", n_gr); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (gr[i] !== i % 4) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, gr[i], i % 4); end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < int'(NREQ); i++) begin
      checks++; if (stat_beats[i*16 +: 16] !== 16'd2) begin errors++;
        $display("FAIL rr_stat_beats%0d: got %0d want 2", i, stat_beats[i*16 +: 16]); end
    end
    checks++; if (stat_stall !== 16'd0) begin errors++; $display("FAIL rr_stat_stall: got %0d want 0", stat_stall); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) push_pkt(1, 1, WID'(8'h50 + k));
    for (int c = 0; c < 7; c++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL b2b cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_wr !== 3) begin errors++; $display("FAIL b2b_nwr: got %0d want 3", n_wr); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_cyc[i] !== 2 * i + 1) begin errors++;
        $display("FAIL b2b_bubble%0d: write at cyc %0d want %0d", i, wr_cyc[i], 2 * i + 1); end
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    push_pkt(1, 20, 8'h10);
    push_pkt(3, 2, 8'h80);
    for (int c = 0; c < 27; c++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL maxb cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_gr !== 3 || gr[0] !== 1 || gr[1] !== 3 || gr[2] !== 1) begin errors++;
      $display("FAIL maxb_grants: got n=%0d %0d,%0d,%0d want 1,3,1", n_gr, gr[0], gr[1], gr[2]); end
    checks++; if (n_wr !== 22) begin errors++; $display("FAIL maxb_nwr: got %0d want 22", n_wr); end
    checks++; if (wr_cyc[15] !== 16 || wr_cyc[16] !== 18) begin errors++;
      $display("FAIL maxb_release: beat16 cyc %0d next cyc %0d want 16/18", wr_cyc[15], wr_cyc[16]); end
    checks++; if (wr_dat[16] !== 8'h80 || wr_dat[17] !== 8'h81 || wr_dat[18] !== 8'h20 || wr_dat[21] !== 8'h23) begin errors++;
      $display("FAIL maxb_data: got %h %h %h %h want 80 81 20 23", wr_dat[16], wr_dat[17], wr_dat[18], wr_dat[21]); end
  endtask

  task automatic test_full_stall();
    do_reset();
    push_pkt(0, 6, 8'hC0);
    for (int c = 0; c < 14; c++) begin
      full_mode = (c >= 3 && c < 8) ? 1 : 0;
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL full cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
      if (c >= 3 && c < 8) begin
        checks++; if (obs_ready[0] !== 1'b0 || obs_wr !== 1'b0) begin errors++;
          $display("FAIL full_hold cyc %0d: ready %b wr_en %b want 0/0", c, obs_ready[0], obs_wr); end
      end
    end
    checks++; if (n_wr !== 6 || wr_cyc[2] !== 8) begin errors++;
      $display("FAIL full_resume: nwr %0d beat2 cyc %0d want 6/8", n_wr, wr_cyc[2]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (wr_dat[i] !== 8'hC0 + WID'(i)) begin errors++;
        $display("FAIL full_order%0d: got %h want %h", i, wr_dat[i], 8'hC0 + WID'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_pkt(2, 4, 8'h30);
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1;
    #1;
    checks++; if ({busy, grant_id, req_ready, fifo_wr_en, fifo_wr_data} !== '0) begin errors++;
      $display("FAIL rstmid_outputs: got %b %0d %b %b %h want all 0", busy, grant_id, req_ready, fifo_wr_en, fifo_wr_data); end
    @(posedge write_clk); #1;
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < int'(NREQ); r++) push_pkt(r, 2, WID'(8'h60 + 16 * r));
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL rstmid cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_gr < 1 || gr[0] !== 0) begin errors++; $display("FAIL rstmid_regrant: got %0d want 0", gr[0]); end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    total = 0;
    for (int r = 0; r < int'(NREQ); r++)
      for (int k = 0; k < 6; k++) begin
        int len;
        len = int'($urandom_range(20, 1));
        push_pkt(r, len, WID'($urandom));
        total += len;
      end
    gap_pct = 25;
    for (int c = 0; c < 700; c++) begin
      full_mode = (c < 350) ? 3 : (c < 450) ? 2 : 0;
      if (c >= 450) gap_pct = 0;
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++;
        $display("FAIL random cyc %0d: got %h want %h", cyc - 1, obs_vec, exp_vec); end
    end
    checks++; if (n_wr !== total) begin errors++; $display("FAIL random_total: got %0d want %0d", n_wr, total); end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < int'(NREQ); i++) begin
      checks++; if (int'(stat_beats[i*16 +: 16]) !== m_beats[i]) begin errors++;
        $display("FAIL random_stat_beats%0d: got %0d want %0d", i, stat_beats[i*16 +: 16], m_beats[i]); end
    end
    checks++; if (int'(stat_stall) !== m_stall) begin errors++;
      $display("FAIL random_stat_stall: got %0d want %0d", stat_stall, m_stall); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_max_burst();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
